// File: rtl/uart_rx_byte_buffer.sv
// Byte FIFO fed by a UART receiver, with the head byte shown on the LEDs,
// a debounced pop button, and sticky overflow/BREAK flags.
module uart_rx_byte_buffer #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         rx_valid,
    input  logic                         rx_break,
    input  logic                         pop_btn,
    input  logic                         clr,
    output logic [DATA_W-1:0]            led_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         break_seen
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } btn_state_t;

    logic              r_btn_meta;
    logic              r_btn_s;
    btn_state_t        r_state;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_pop;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;
    logic              r_break_seen;
    logic [DATA_W-1:0] r_led;

    logic              w_wr_req;
    logic              w_brk;
    logic              w_pop_ok;
    logic              w_do_wr;
    logic              w_drop;
    logic [PTR_W-1:0]  w_wr_nxt;
    logic [PTR_W-1:0]  w_rd_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_led_nxt;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_btn_meta <= pop_btn;
            r_btn_s    <= r_btn_meta;
        end
    end

    // Debounce FSM; one pop pulse per accepted press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RELEASED;
            r_db_cnt <= '0;
            r_pop    <= 1'b0;
        end else begin
            r_pop <= 1'b0;
            case (r_state)
                ST_RELEASED: begin
                    r_db_cnt <= '0;
                    if (r_btn_s) r_state <= ST_PRESS_WAIT;
                end
                ST_PRESS_WAIT: begin
                    if (!r_btn_s) begin
                        r_state  <= ST_RELEASED;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_MAX) begin
                        r_state  <= ST_PRESSED;
                        r_db_cnt <= '0;
                        r_pop    <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end
                ST_PRESSED: begin
                    r_db_cnt <= '0;
                    if (!r_btn_s) r_state <= ST_RELEASE_WAIT;
                end
                ST_RELEASE_WAIT: begin
                    if (r_btn_s) begin
                        r_state  <= ST_PRESSED;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_MAX) begin
                        r_state  <= ST_RELEASED;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_RELEASED;
                    r_db_cnt <= '0;
                end
            endcase
        end
    end

    // FIFO next-state decode; a pop on a full FIFO frees the slot for a same-cycle write
    always_comb begin
        w_wr_req    = rx_valid & ~rx_break;
        w_brk       = rx_valid & rx_break;
        w_pop_ok    = r_pop & ~r_empty;
        w_do_wr     = w_wr_req & (~r_full | w_pop_ok);
        w_drop      = w_wr_req & r_full & ~w_pop_ok;
        w_wr_nxt    = w_do_wr  ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
        w_rd_nxt    = w_pop_ok ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
        w_count_nxt = r_count + CNT_W'(w_do_wr) - CNT_W'(w_pop_ok);
        w_led_nxt   = '0;
        if (w_count_nxt != '0) begin
            if (w_do_wr && (w_rd_nxt == r_wr_ptr)) w_led_nxt = rx_data;
            else                                   w_led_nxt = r_mem[w_rd_nxt];
        end
    end

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (w_do_wr && !clr) r_mem[r_wr_ptr] <= rx_data;
    end

    // Pointers, count, status and head byte; clr wins over everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
            r_overflow   <= 1'b0;
            r_break_seen <= 1'b0;
            r_led        <= '0;
        end else if (clr) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
            r_overflow   <= 1'b0;
            r_break_seen <= 1'b0;
            r_led        <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            r_empty  <= (w_count_nxt == '0);
            r_full   <= (w_count_nxt == CNT_FULL);
            r_led    <= w_led_nxt;
            if (w_drop) r_overflow   <= 1'b1;
            if (w_brk)  r_break_seen <= 1'b1;
        end
    end

    assign led_data   = r_led;
    assign count      = r_count;
    assign empty      = r_empty;
    assign full       = r_full;
    assign overflow   = r_overflow;
    assign break_seen = r_break_seen;

endmodule

// File: tb/tb_uart_rx_byte_buffer.sv
// Directed bench for uart_rx_byte_buffer with DEPTH=8 and DEBOUNCE_CYCLES=4.
module tb_uart_rx_byte_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_break;
    logic       pop_btn;
    logic       clr;
    logic [7:0] led_data;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       break_seen;

    int checks = 0;
    int errors = 0;

    uart_rx_byte_buffer #(
        .DATA_W          (8),
        .DEPTH           (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_break   (rx_break),
        .pop_btn    (pop_btn),
        .clr        (clr),
        .led_data   (led_data),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .break_seen (break_seen)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Clean press long enough for one pop, then a full debounced release
    task automatic press();
        pop_btn = 1'b1;
        repeat (8) tick();
        pop_btn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_data = '0; rx_valid = 0; rx_break = 0; pop_btn = 0; clr = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (led_data !== 8'h00) begin errors++; $display("FAIL reset_led got %h exp 00", led_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        checks++; if (break_seen !== 1'b0) begin errors++; $display("FAIL reset_brk got %b exp 0", break_seen); end
    endtask

    task automatic test_write_pop();
        write_byte(8'hA5);
        checks++; if (led_data !== 8'hA5) begin errors++; $display("FAIL wp_first_visible got %h exp a5", led_data); end
        write_byte(8'h3C);
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL wp_count2 got %0d exp 2", count); end
        checks++; if (led_data !== 8'hA5) begin errors++; $display("FAIL wp_head got %h exp a5", led_data); end
        pop_btn = 1'b1;
        repeat (7) tick();
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL wp_pop_early got %0d exp 2", count); end
        tick();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL wp_pop_latency got %0d exp 1", count); end
        checks++; if (led_data !== 8'h3C) begin errors++; $display("FAIL wp_pop_led got %h exp 3c", led_data); end
        repeat (4) tick();
        pop_btn = 1'b0;
        repeat (10) tick();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL wp_hold_no_repeat got %0d exp 1", count); end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            pop_btn = ~pop_btn;
            repeat (2) tick();
        end
        pop_btn = 1'b0;
        repeat (10) tick();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL bounce_count got %0d exp 1", count); end
        checks++; if (led_data !== 8'h3C) begin errors++; $display("FAIL bounce_led got %h exp 3c", led_data); end
    endtask

    task automatic test_overflow();
        press();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_pre_empty got %b exp 1", empty); end
        for (int i = 0; i < 8; i++) write_byte(8'(i));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
        write_byte(8'hFF);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (led_data !== 8'h00) begin errors++; $display("FAIL ovf_head got %h exp 00", led_data); end
        for (int i = 1; i < 8; i++) begin
            press();
            checks++; if (led_data !== 8'(i)) begin errors++; $display("FAIL ovf_drain_led[%0d] got %h exp %h", i, led_data, 8'(i)); end
            checks++; if (count !== 4'(8 - i)) begin errors++; $display("FAIL ovf_drain_cnt[%0d] got %0d exp %0d", i, count, 8 - i); end
        end
        press();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_final_empty got %b exp 1", empty); end
        checks++; if (led_data !== 8'h00) begin errors++; $display("FAIL ovf_final_led got %h exp 00", led_data); end
        press();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL pop_when_empty got %0d exp 0", count); end
    endtask

    task automatic test_full_simul();
        clr = 1'b1; tick(); clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fs_clr_ovf got %b exp 0", overflow); end
        for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i));
        pop_btn = 1'b1;
        repeat (7) tick();
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fs_before got %0d exp 8", count); end
        rx_data = 8'h55; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fs_count got %0d exp 8", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fs_ovf got %b exp 0", overflow); end
        checks++; if (led_data !== 8'h11) begin errors++; $display("FAIL fs_head got %h exp 11", led_data); end
        pop_btn = 1'b0;
        repeat (10) tick();
        for (int i = 2; i < 8; i++) begin
            press();
            checks++; if (led_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL fs_drain[%0d] got %h exp %h", i, led_data, 8'h10 + 8'(i)); end
        end
        press();
        checks++; if (led_data !== 8'h55) begin errors++; $display("FAIL fs_last_led got %h exp 55", led_data); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL fs_last_cnt got %0d exp 1", count); end
        press();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fs_empty got %b exp 1", empty); end
    endtask

    task automatic test_break_clear();
        write_byte(8'h77);
        rx_break = 1'b1;
        write_byte(8'h00);
        rx_break = 1'b0;
        checks++; if (break_seen !== 1'b1) begin errors++; $display("FAIL brk_flag got %b exp 1", break_seen); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL brk_count got %0d exp 1", count); end
        checks++; if (led_data !== 8'h77) begin errors++; $display("FAIL brk_led got %h exp 77", led_data); end
        clr = 1'b1;
        write_byte(8'h99);
        clr = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", count); end
        checks++; if (break_seen !== 1'b0) begin errors++; $display("FAIL clr_brk got %b exp 0", break_seen); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL clr_empty got %b exp 1", empty); end
        checks++; if (led_data !== 8'h00) begin errors++; $display("FAIL clr_led got %h exp 00", led_data); end
    endtask

    task automatic test_reset_mid_press();
        write_byte(8'hEE);
        pop_btn = 1'b1;
        repeat (4) tick();
        rst_n   = 1'b0;
        pop_btn = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_async_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_async_empty got %b exp 1", empty); end
        repeat (2) tick();
        rst_n = 1'b1;
        write_byte(8'h11);
        write_byte(8'h22);
        repeat (15) tick();
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL rst_no_pop_cnt got %0d exp 2", count); end
        checks++; if (led_data !== 8'h11) begin errors++; $display("FAIL rst_no_pop_led got %h exp 11", led_data); end
    endtask

    initial begin
        test_reset();
        test_write_pop();
        test_bounce();
        test_overflow();
        test_full_simul();
        test_break_clear();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
